median_filter_stream: RTL and testbench

- Streaming sliding-window median filter: parametrised successor of the 3-input combinational median finder.
- Accepts one sample per cycle over a valid/ready handshake and holds the last WIN samples in an age-tagged sorted register array.
- Emits the window median for every accepted sample once the window is full.
- Sits between a sample source and downstream processing as a denoising stage (salt-and-pepper removal).

---
 rtl/mf_pkg.sv | 16 +
 rtl/median_sort_slot.sv | 73 +++++++
 rtl/median_filter_stream.sv | 115 +++++++++++
 tb/tb_median_filter_stream.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mf_pkg.sv
// Shared constants and width helpers for the streaming median filter.
// slot_t is declared locally from these helpers, since packages cannot take DATA_W.
package mf_pkg;

  localparam int WIN_MAX = 9;

  function automatic int age_w(input int win);
    return (win > 2) ? $clog2(win) : 1;
  endfunction

  // Packed slot layout, MSB first: {occupied, age[age_w-1:0], value[data_w-1:0]}
  function automatic int slot_w(input int data_w, input int win);
    return 1 + age_w(win) + data_w;
  endfunction

endpackage

// File: rtl/median_sort_slot.sv
// One position of the sorted window: chooses its next occupant from itself,
// its neighbours or the incoming sample, so the array stays sorted after each accept.
module median_sort_slot
  import mf_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int WIN    = 3,
  parameter int IDX    = 0,
  localparam int AGE_W = age_w(WIN),
  localparam int CNT_W = $clog2(WIN + 1),
  localparam int SW    = slot_w(DATA_W, WIN)
) (
  input  logic [SW-1:0]     below,
  input  logic [SW-1:0]     cur,
  input  logic [SW-1:0]     above,
  input  logic              below_rmb,
  input  logic              cur_rmb,
  input  logic              above_rmb,
  input  logic [DATA_W-1:0] sample,
  input  logic [AGE_W-1:0]  evict_age,
  input  logic              insert,
  input  logic              remove,
  input  logic [CNT_W-1:0]  ins_pos,
  output logic [SW-1:0]     nxt_slot
);

  typedef struct packed {
    logic              occupied;
    logic [AGE_W-1:0]  age;
    logic [DATA_W-1:0] value;
  } slot_t;

  slot_t b, c, a, n;
  logic  le_b, le_c, le_a;
  logic  hit_b, hit_c, hit_a;

  assign b = below;
  assign c = cur;
  assign a = above;

  // le: entry sorts at or below the sample (ties keep older entries lower).
  assign le_b  = b.occupied && (b.value <= sample);
  assign le_c  = c.occupied && (c.value <= sample);
  assign le_a  = a.occupied && (a.value <= sample);
  assign hit_b = remove && b.occupied && (b.age == evict_age);
  assign hit_c = remove && c.occupied && (c.age == evict_age);
  assign hit_a = remove && a.occupied && (a.age == evict_age);

  // An entry moves down one when an eviction sits below it and it stays below the
  // new sample, moves up one when neither holds, and otherwise keeps its place.
  always_comb begin
    n = '0;
    if (!insert) begin
      n = c;
    end else if (ins_pos == CNT_W'(IDX)) begin
      n.occupied = 1'b1;
      n.age      = '0;
      n.value    = sample;
    end else if (a.occupied && !hit_a && above_rmb && le_a) begin
      n     = a;
      n.age = a.age + 1'b1;
    end else if (b.occupied && !hit_b && !below_rmb && !le_b) begin
      n     = b;
      n.age = b.age + 1'b1;
    end else if (c.occupied && !hit_c && (cur_rmb ^ le_c)) begin
      n     = c;
      n.age = c.age + 1'b1;
    end
  end

  assign nxt_slot = n;

endmodule

// File: rtl/median_filter_stream.sv
// Streaming sliding-window median filter with valid/ready handshake and a single
// output register; the window is an age-tagged array kept sorted by value.
module median_filter_stream
  import mf_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int WIN    = 3,
  parameter int CNT_W  = $clog2(WIN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_median,
  output logic              win_full
);

  if (WIN < 3 || WIN > WIN_MAX || (WIN % 2) == 0 || CNT_W != $clog2(WIN + 1)) begin : g_bad_cfg
    $error("median_filter_stream: WIN must be odd in 3..%0d with derived CNT_W", WIN_MAX);
  end

  localparam int AGE_W = age_w(WIN);
  localparam int MID   = WIN / 2;
  localparam logic [AGE_W-1:0] EVICT_AGE = AGE_W'(WIN - 1);
  localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WIN);
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(WIN - 1);

  typedef struct packed {
    logic              occupied;
    logic [AGE_W-1:0]  age;
    logic [DATA_W-1:0] value;
  } slot_t;

  slot_t            slots    [WIN];
  slot_t            slot_nxt [WIN];
  slot_t            pad      [WIN+2];
  logic [WIN+1:0]   rmb_pad;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] ins_pos;
  logic             full;
  logic             accept;
  logic             fills;

  assign full     = (count == WIN_CNT);
  assign win_full = full;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign fills    = full || (count == LAST_FILL);

  // Padded neighbour view plus "eviction below" prefix; the insert position is the
  // number of surviving entries that sort at or below the sample.
  always_comb begin
    logic             seen;
    logic             hit_le;
    logic [CNT_W-1:0] le_cnt;
    seen       = 1'b0;
    hit_le     = 1'b0;
    le_cnt     = '0;
    rmb_pad    = '0;
    pad[0]     = '0;
    pad[WIN+1] = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      pad[i+1]     = slots[i];
      rmb_pad[i+1] = seen;
      if (slots[i].occupied && (slots[i].value <= in_data)) begin
        le_cnt = le_cnt + 1'b1;
        if (full && (slots[i].age == EVICT_AGE)) hit_le = 1'b1;
      end
      if (full && slots[i].occupied && (slots[i].age == EVICT_AGE)) seen = 1'b1;
    end
    ins_pos = le_cnt - CNT_W'(hit_le);
  end

  for (genvar i = 0; i < WIN; i++) begin : g_slot
    median_sort_slot #(
      .DATA_W (DATA_W),
      .WIN    (WIN),
      .IDX    (i)
    ) u_slot (
      .below     (pad[i]),
      .cur       (pad[i+1]),
      .above     (pad[i+2]),
      .below_rmb (rmb_pad[i]),
      .cur_rmb   (rmb_pad[i+1]),
      .above_rmb (rmb_pad[i+2]),
      .sample    (in_data),
      .evict_age (EVICT_AGE),
      .insert    (accept),
      .remove    (full),
      .ins_pos   (ins_pos),
      .nxt_slot  (slot_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < WIN; i++) slots[i] <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      if (rst) out_median <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < WIN; i++) slots[i] <= slot_nxt[i];
      if (!full) count <= count + 1'b1;
      out_valid <= fills;
      if (fills) out_median <= slot_nxt[MID].value;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_median_filter_stream.sv
// Scoreboard bench for median_filter_stream at WIN=3 and WIN=5 (DATA_W=4).
module tb_median_filter_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       flush3, in_valid3, in_ready3, out_valid3, out_ready3, win_full3;
  logic [3:0] in_data3, out_median3;
  logic       flush5, in_valid5, in_ready5, out_valid5, out_ready5, win_full5;
  logic [3:0] in_data5, out_median5;

  median_filter_stream #(.DATA_W(4), .WIN(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_median(out_median3), .win_full(win_full3)
  );

  median_filter_stream #(.DATA_W(4), .WIN(5)) dut5 (
    .clk(clk), .rst(rst), .flush(flush5), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_data(in_data5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_median(out_median5), .win_full(win_full5)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp3[$], win3[$], got3[$];
  int exp5[$], win5[$], got5[$];
  logic rand_done = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int median_of(input int q[$]);
    int s[$];
    s = q;
    s.sort();
    return s[s.size() / 2];
  endfunction

  task automatic expect_list(input string tag, input int got[$], input int e[8], input int n);
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check(tag, got[i], e[i]);
  endtask

  // Reference window model: accepts push expected medians, handshakes pop them.
  always @(negedge clk) begin
    if (rst || flush3) begin
      exp3.delete();
      win3.delete();
    end else begin
      if (out_valid3 && out_ready3) begin
        got3.push_back(int'(out_median3));
        if (exp3.size() == 0) check("unexpected_out3", 1, 0);
        else check("median3", out_median3, exp3.pop_front());
      end
      if (in_valid3 && in_ready3) begin
        win3.push_back(int'(in_data3));
        if (win3.size() > 3) win3.delete(0);
        if (win3.size() == 3) exp3.push_back(median_of(win3));
      end
    end
  end

  always @(negedge clk) begin
    if (rst || flush5) begin
      exp5.delete();
      win5.delete();
    end else begin
      if (out_valid5 && out_ready5) begin
        got5.push_back(int'(out_median5));
        if (exp5.size() == 0) check("unexpected_out5", 1, 0);
        else check("median5", out_median5, exp5.pop_front());
      end
      if (in_valid5 && in_ready5) begin
        win5.push_back(int'(in_data5));
        if (win5.size() > 5) win5.delete(0);
        if (win5.size() == 5) exp5.push_back(median_of(win5));
      end
    end
  end

  task automatic send3(input int v);
    int n = 0;
    in_valid3 = 1'b1;
    in_data3  = 4'(v);
    @(negedge clk);
    while (!in_ready3 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("send3_ready", in_ready3, 1);
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
  endtask

  task automatic send5(input int v);
    int n = 0;
    in_valid5 = 1'b1;
    in_data5  = 4'(v);
    @(negedge clk);
    while (!in_ready5 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("send5_ready", in_ready5, 1);
    @(posedge clk);
    #1;
    in_valid5 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush3_pulse();
    flush3 = 1'b1;
    @(posedge clk);
    #1;
    flush3 = 1'b0;
    got3.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[8];
    flush3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;
    flush5 = 1'b0; in_valid5 = 1'b0; in_data5 = '0; out_ready5 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid3, 0);
    check("rst_out_median", out_median3, 0);
    check("rst_win_full", win_full3, 0);
    check("rst_in_ready", in_ready3, 1);
    check("rst_in_ready5", in_ready5, 1);
    @(posedge clk);
    #1;

    // 5,1,9,2,9 -> 5,2,9
    got3.delete();
    send3(5);
    check("fill1_valid", out_valid3, 0);
    send3(1);
    check("fill2_valid", out_valid3, 0);
    check("fill2_full", win_full3, 0);
    send3(9);
    check("first_full", win_full3, 1);
    check("first_valid", out_valid3, 1);
    check("first_median", out_median3, 5);
    send3(2);
    send3(9);
    idle(3);
    e = '{5, 2, 9, 0, 0, 0, 0, 0};
    expect_list("stream_a", got3, e, 3);

    // Ties: 7,7,7,15,0,15 -> 7,7,7,15
    flush3_pulse();
    check("flush_win_full", win_full3, 0);
    send3(7); send3(7); send3(7); send3(15); send3(0); send3(15);
    idle(3);
    e = '{7, 7, 7, 15, 0, 0, 0, 0};
    expect_list("ties", got3, e, 4);

    // Backpressure holds output and window
    flush3_pulse();
    send3(5);
    send3(1);
    out_ready3 = 1'b0;
    send3(9);
    in_valid3 = 1'b1;
    in_data3  = 4'd2;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("hold_median", out_median3, 5);
      check("hold_valid", out_valid3, 1);
      check("hold_in_ready", in_ready3, 0);
    end
    @(posedge clk);
    #1 out_ready3 = 1'b1;
    send3(2);
    check("release_median", out_median3, 2);
    idle(3);
    e = '{5, 2, 0, 0, 0, 0, 0, 0};
    expect_list("backpressure", got3, e, 2);

    // Flush beats a simultaneous accept
    flush3_pulse();
    send3(5);
    send3(1);
    flush3    = 1'b1;
    in_valid3 = 1'b1;
    in_data3  = 4'd9;
    @(negedge clk);
    check("flush_in_ready", in_ready3, 1);
    @(posedge clk);
    #1;
    flush3    = 1'b0;
    in_valid3 = 1'b0;
    got3.delete();
    check("flush_drop_full", win_full3, 0);
    check("flush_drop_valid", out_valid3, 0);
    send3(4); send3(8); send3(6);
    idle(3);
    e = '{6, 0, 0, 0, 0, 0, 0, 0};
    expect_list("flush_drop", got3, e, 1);

    // Reset mid-stream with a pending output
    flush3_pulse();
    send3(5); send3(1); send3(9);
    check("pre_rst_valid", out_valid3, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_valid", out_valid3, 0);
    check("mid_rst_median", out_median3, 0);
    check("mid_rst_full", win_full3, 0);
    check("mid_rst_in_ready", in_ready3, 1);
    send3(4);
    check("refill1_valid", out_valid3, 0);
    send3(8);
    check("refill2_valid", out_valid3, 0);
    send3(6);
    check("refill3_valid", out_valid3, 1);
    check("refill3_median", out_median3, 6);
    idle(3);

    // WIN=5: 3,8,1,6,4,0,10 -> 4,4,4
    got5.delete();
    send5(3); send5(8); send5(1); send5(6);
    check("w5_fill_valid", out_valid5, 0);
    send5(4);
    check("w5_full", win_full5, 1);
    send5(0); send5(10);
    idle(3);
    e = '{4, 4, 4, 0, 0, 0, 0, 0};
    expect_list("win5", got5, e, 3);

    // Random stream with random backpressure on both instances
    fork
      begin
        fork
          begin
            for (int k = 0; k < 40; k++) send3(int'($urandom_range(0, 15)));
          end
          begin
            for (int k = 0; k < 40; k++) send5(int'($urandom_range(0, 15)));
          end
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready3 = 1'($urandom_range(0, 1));
          out_ready5 = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready3 = 1'b1;
    out_ready5 = 1'b1;
    idle(10);
    check("drain3", exp3.size(), 0);
    check("drain5", exp5.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
